// File: rtl/keycode_event_reader.sv
// Debounces game keys from the four-byte HID keycode word and queues one event per press in a show-ahead FIFO.
// Optional build macro KEY_AUTOREPEAT_EN adds hold-to-repeat for the four direction codes.
module keycode_event_reader #(
    parameter int unsigned FIFO_DEPTH    = 4,
    parameter int unsigned STABLE_CYCLES = 1000000,
    parameter int unsigned REPEAT_DELAY  = 40000000,
    parameter int unsigned REPEAT_PERIOD = 10000000
) (
    input  logic                          Clk,
    input  logic                          reset_rtl_0,
    input  logic [31:0]                   keycode_word,
    output logic                          evt_valid,
    output logic [2:0]                    evt_code,
    input  logic                          evt_ready,
    output logic [5:0]                    keys_held,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned SW = $clog2(STABLE_CYCLES);

    // Elaboration-time guard against unsupported configurations.
    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two in 2..16");
    end
    if (STABLE_CYCLES < 2) begin : g_bad_stable
        $error("STABLE_CYCLES must be at least 2");
    end
    if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
        $error("REPEAT_DELAY and REPEAT_PERIOD must be at least 1");
    end

    logic [31:0]                 kc_q;
    logic [5:0]                  cand_q, cand_d, cand_map;
    logic                        rollover;
    logic [SW-1:0]               stab_q, stab_d;
    logic [5:0]                  held_q, held_d, prev_q;
    logic [5:0]                  pend_q, pend_d, pend_avail;
    logic [5:0]                  rise, push_mask, rpt_fire;
    logic                        ovf_q, ovf_d;
    logic [FIFO_DEPTH-1:0][2:0]  mem_q;
    logic [PW-1:0]               wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]               count_q, count_d;
    logic [2:0]                  push_code;
    logic                        push, pop, full;

    function automatic logic [5:0] map_byte(input logic [7:0] b);
        logic [5:0] m;
        m = '0;
        case (b)
            8'h52, 8'h1A: m[0] = 1'b1;
            8'h51, 8'h16: m[1] = 1'b1;
            8'h50, 8'h04: m[2] = 1'b1;
            8'h4F, 8'h07: m[3] = 1'b1;
            8'h28:        m[4] = 1'b1;
            8'h2C:        m[5] = 1'b1;
            default:      m    = '0;
        endcase
        return m;
    endfunction

    // Candidate key set; an ErrorRollOver byte freezes the candidate.
    always_comb begin
        cand_map = map_byte(kc_q[7:0]) | map_byte(kc_q[15:8])
                 | map_byte(kc_q[23:16]) | map_byte(kc_q[31:24]);
        rollover = (kc_q[7:0] == 8'h01) || (kc_q[15:8] == 8'h01)
                || (kc_q[23:16] == 8'h01) || (kc_q[31:24] == 8'h01);
    end

    // Debounce window: any candidate change restarts the full count.
    always_comb begin
        cand_d = cand_q;
        stab_d = stab_q;
        held_d = held_q;
        if (!rollover && (cand_map != cand_q)) begin
            cand_d = cand_map;
            stab_d = '0;
        end else if (stab_q == SW'(STABLE_CYCLES - 1)) begin
            held_d = cand_q;
        end else begin
            stab_d = stab_q + SW'(1);
        end
    end

    assign rise = held_q & ~prev_q;

`ifdef KEY_AUTOREPEAT_EN
    localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned RW   = (RMAX > 1) ? $clog2(RMAX) : 1;

    // Per-direction down-counter; reloads with the delay on press, the period after each repeat.
    for (genvar g = 0; g < 4; g++) begin : g_rpt
        logic [RW-1:0] cnt_q, cnt_d;
        logic          fire_c;

        always_comb begin
            cnt_d  = cnt_q;
            fire_c = 1'b0;
            if (!held_q[g]) begin
                cnt_d = '0;
            end else if (!prev_q[g]) begin
                cnt_d = RW'(REPEAT_DELAY - 1);
            end else if (cnt_q == '0) begin
                fire_c = 1'b1;
                cnt_d  = RW'(REPEAT_PERIOD - 1);
            end else begin
                cnt_d = cnt_q - RW'(1);
            end
        end

        always_ff @(posedge Clk) begin
            if (!reset_rtl_0) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign rpt_fire[g] = fire_c;
    end
    assign rpt_fire[5:4] = 2'b00;
`else
    assign rpt_fire = '0;
`endif

    // Serializer picks the lowest pending code.
    always_comb begin
        push_code = 3'd0;
        if      (pend_q[0]) push_code = 3'd0;
        else if (pend_q[1]) push_code = 3'd1;
        else if (pend_q[2]) push_code = 3'd2;
        else if (pend_q[3]) push_code = 3'd3;
        else if (pend_q[4]) push_code = 3'd4;
        else if (pend_q[5]) push_code = 3'd5;
    end

    // FIFO control; a full FIFO still accepts a push when the head is popped on the same edge.
    always_comb begin
        full       = (count_q == CW'(FIFO_DEPTH));
        pop        = (count_q != '0) && evt_ready;
        push       = (pend_q != '0) && (!full || pop);
        push_mask  = push ? (6'd1 << push_code) : 6'd0;
        pend_avail = pend_q & ~push_mask;
        pend_d     = pend_avail | rise | rpt_fire;
        ovf_d      = ovf_q || ((pend_avail & (rise | rpt_fire)) != '0);
        wr_ptr_d   = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d    = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!reset_rtl_0) begin
            kc_q     <= '0;
            cand_q   <= '0;
            stab_q   <= '0;
            held_q   <= '0;
            prev_q   <= '0;
            pend_q   <= '0;
            ovf_q    <= 1'b0;
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            kc_q     <= keycode_word;
            cand_q   <= cand_d;
            stab_q   <= stab_d;
            held_q   <= held_d;
            prev_q   <= held_q;
            pend_q   <= pend_d;
            ovf_q    <= ovf_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push) begin
                mem_q[wr_ptr_q] <= push_code;
            end
        end
    end

    assign evt_valid  = (count_q != '0);
    assign evt_code   = mem_q[rd_ptr_q];
    assign keys_held  = held_q;
    assign fifo_count = count_q;
    assign overflow   = ovf_q;

endmodule

// File: doc/keycode_event_reader.md
# keycode_event_reader

Reads the four-byte HID keycode word that the MicroBlaze USB firmware writes to the keycode GPIO. Debounces the set of game-relevant keys and turns each new key press into a single event. Events are queued in a small show-ahead FIFO with a valid/ready handshake, so game logic (snake control, start/pause) takes discrete commands instead of polling raw keycodes. The block sits in the `Clk` (100 MHz) domain between `mb_usb` and the game FSM.

## Interface
Parameters:
- `FIFO_DEPTH`, 4: event FIFO entries; power of two, 2..16.
- `STABLE_CYCLES`, 1000000: cycles a candidate key set must stay unchanged before it is accepted (10 ms at 100 MHz); minimum 2.
- `REPEAT_DELAY`, 40000000: hold time before the first auto-repeat; used only with `KEY_AUTOREPEAT_EN`.
- `REPEAT_PERIOD`, 10000000: interval between later auto-repeats; used only with `KEY_AUTOREPEAT_EN`.

Ports:
- `Clk`  in  1  system clock, 100 MHz.
- `reset_rtl_0`  in  1  reset; synchronous, active-low.
- `keycode_word`  in  32  four HID usage bytes. Byte 0 is [7:0]; byte 3 is [31:24].
- `evt_valid`  out  1  FIFO head holds an event.
- `evt_code`  out  3  head event: 0 UP, 1 DOWN, 2 LEFT, 3 RIGHT, 4 START, 5 PAUSE.
- `evt_ready`  in  1  consumer accepts the head this cycle.
- `keys_held`  out  6  debounced level per code, where bit n is code n.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  number of queued events.
- `overflow`  out  1  sticky flag: a press was merged or lost. Cleared only by reset.

## Operation
- Input stage: `keycode_word` is registered once into `kc_q`.
- Key mapping, applied to each byte of `kc_q`; the results are ORed into a 6-bit candidate:
  - 0x52/0x1A → UP
  - 0x51/0x16 → DOWN
  - 0x50/0x04 → LEFT
  - 0x4F/0x07 → RIGHT
  - 0x28 → START
  - 0x2C → PAUSE
  - 0x00 and all other codes are ignored.
- ErrorRollOver: if any byte is 0x01, the whole word is discarded and the candidate keeps its previous value.
- Debounce:
  - `cand_q` holds the candidate; counter `stab_cnt` has width $clog2(STABLE_CYCLES).
  - When the candidate differs from `cand_q`: load `cand_q`, clear `stab_cnt`.
  - Otherwise, if `stab_cnt` == STABLE_CYCLES-1: load `keys_held` <= `cand_q` and hold the counter.
  - Otherwise: increment `stab_cnt`.
- Edge detect: bits rising in `keys_held` (`keys_held` & ~previous) are ORed into a 6-bit `pending` mask. If a bit rises while it is already set in `pending`, set `overflow`. Key releases generate no event.
- Serializer: each cycle where `pending` ≠ 0 and a push is allowed:
  - push the lowest set index into the FIFO;
  - clear that bit in `pending` on the same edge.
- Push rule: a push is allowed when the FIFO is not full, or when it is full and a pop happens in the same cycle. In the full-with-pop case `fifo_count` stays unchanged.
- While the FIFO is full with no pop, `pending` holds its bits. No event is dropped silently.
- Handshake:
  - The FIFO is show-ahead: `evt_code` is valid whenever `evt_valid` = 1.
  - A pop occurs when `evt_valid` & `evt_ready`.
  - `evt_ready` while empty has no effect.
  - `evt_code` must stay stable while `evt_valid` = 1 and `evt_ready` = 0.
- Reset: when `reset_rtl_0` is sampled low, every register clears on that edge, including a reset that arrives mid-debounce or with the FIFO non-empty. Queued and pending events are discarded.

## Timing
- Reset values:
  - `evt_valid` 0, `evt_code` 0, `keys_held` 0, `fifo_count` 0, `overflow` 0.
  - Internally: `cand_q` 0, `stab_cnt` 0, `pending` 0.
- Press latency, measured from edge E0 where the new word enters `kc_q`, with the FIFO empty and no events pending:
  - `cand_q` loads at E0+1.
  - `keys_held` updates at E0+1+STABLE_CYCLES.
  - `pending` sets at E0+2+STABLE_CYCLES.
  - `evt_valid` rises at E0+3+STABLE_CYCLES.
- Throughput: the FIFO accepts one push per cycle and delivers one pop per cycle.
- Simultaneous presses: n keys that become stable together produce events on n consecutive cycles, in ascending code order.
- Glitches: a candidate change at any count restarts the full STABLE_CYCLES window.
- Pointers wrap modulo FIFO_DEPTH.
- `fifo_count` updates on the edge after the push or pop.

## Configuration
- `KEY_AUTOREPEAT_EN` defined:
  - Each held code 0..3 (directions only) has a shared-structure repeat timer.
  - The first repeat fires REPEAT_DELAY cycles after the code's bit in `keys_held` rises; later repeats fire every REPEAT_PERIOD cycles while the bit stays 1.
  - A repeat ORs the code into `pending`, subject to the normal `overflow` rule.
  - The timer clears on release.
  - START and PAUSE never repeat.
- `KEY_AUTOREPEAT_EN` not defined: the repeat logic and counters are not compiled. REPEAT_* parameters are ignored. Exactly one event is produced per press.

## Test plan
Test parameters: STABLE_CYCLES=4, FIFO_DEPTH=4.
- Reset behaviour: hold `reset_rtl_0`=0 with `keycode_word`=0x0000_001A → all outputs 0. Release reset → `evt_valid` rises 7 cycles after the first post-reset capture, with `evt_code`=0. `keys_held`=6'b000001.
- Glitch and rollover:
  - Toggle `keycode_word` between 0x00 and 0x07 every 2 cycles for 20 cycles, then hold 0x00 → no event.
  - Apply word 0x0101_0101 → no change to `keys_held`.
- Simultaneous presses: apply 0x2C28_4F50 (PAUSE, START, RIGHT, LEFT) with `evt_ready`=1 → events 2, 3, 4, 5 on four consecutive cycles.
- Backpressure and merge:
  - Hold `evt_ready`=0 and make five distinct presses → `fifo_count`=4, fifth code held in `pending`, `evt_code` stable.
  - Re-press the pending key → `overflow`=1.
  - Set `evt_ready`=1 → the pending code is pushed in the same cycle as the first pop.
- Reset mid-operation: with 3 events queued, pulse `reset_rtl_0` low for 1 cycle → `fifo_count`=0, `evt_valid`=0 on that edge.
- Auto-repeat, with `KEY_AUTOREPEAT_EN`, REPEAT_DELAY=10, REPEAT_PERIOD=5: hold 0x52 for 30 cycles after it becomes stable → 1 press event plus repeats at +10, +15, +20, +25. Hold 0x28 the same way → 1 event only.
